// File: rtl/pipe_ctrl_if.sv
// ID-stage instruction fields in, pipeline control and hazard signals out.
// The master side is the datapath; the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int RA_W = 5
);
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [RA_W-1:0] rs;
  logic [RA_W-1:0] rt;
  logic [RA_W-1:0] rd;
  logic            hold;
  logic            br_taken;

  logic            J;
  logic            BEQ;
  logic            BNE;
  logic            ExtOP;
  logic            stall;
  logic            flush;
  logic [1:0]      ex_aluop;
  logic            ex_b_invert;
  logic            ex_alusrc;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            mem_write;
  logic            mem_mem2reg;
  logic            wb_write_en;
  logic [RA_W-1:0] wb_dst;

  modport master (
    output opcode, funct, rs, rt, rd, hold, br_taken,
    input  J, BEQ, BNE, ExtOP, stall, flush, ex_aluop, ex_b_invert, ex_alusrc,
           fwd_a, fwd_b, mem_write, mem_mem2reg, wb_write_en, wb_dst
  );

  modport slave (
    input  opcode, funct, rs, rt, rd, hold, br_taken,
    output J, BEQ, BNE, ExtOP, stall, flush, ex_aluop, ex_b_invert, ex_alusrc,
           fwd_a, fwd_b, mem_write, mem_mem2reg, wb_write_en, wb_dst
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use / RAW stall detection, branch/jump flush and EX forwarding.
module pipe_ctrl #(
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input logic        CLK,
  input logic        RST_N,
  pipe_ctrl_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] dst;
    alu_op_e         aluop;
    logic            b_inv;
    logic            alusrc;
    logic            mem_write;
    logic            mem2reg;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
  } id_ex_t;

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] dst;
    logic            mem_write;
    logic            mem2reg;
  } ex_mem_t;

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] dst;
  } mem_wb_t;

  ctrl_t   dec;
  logic    dec_j, dec_beq, dec_bne, dec_ext;
  logic    use_rs, use_rt, r_ok, i_wr;
  logic    hit_ex, hit_mem, stall_raw, stall, bubble;
  logic    [1:0] fwd_a, fwd_b;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  // Undefined opcodes/functs fall through with every enable left at zero (NOP).
  always_comb begin
    dec     = '0;
    dec_j   = 1'b0;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    dec_ext = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    r_ok    = 1'b0;
    i_wr    = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          6'h20, 6'h21: begin r_ok = 1'b1; dec.aluop = ALU_ADD; end
          6'h22, 6'h23: begin r_ok = 1'b1; dec.aluop = ALU_ADD; dec.b_inv = 1'b1; end
          6'h24:        begin r_ok = 1'b1; dec.aluop = ALU_AND; end
          6'h25:        begin r_ok = 1'b1; dec.aluop = ALU_OR; end
          6'h2A:        begin r_ok = 1'b1; dec.aluop = ALU_SLT; dec.b_inv = 1'b1; end
          default: ;
        endcase
        if (r_ok) begin
          dec.we  = 1'b1;
          dec.dst = bus.rd;
          use_rs  = 1'b1;
          use_rt  = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU: begin dec.aluop = ALU_ADD; dec_ext = 1'b1; i_wr = 1'b1; end
      OP_SLTI: begin dec.aluop = ALU_SLT; dec.b_inv = 1'b1; i_wr = 1'b1; end
      OP_ANDI: begin dec.aluop = ALU_AND; i_wr = 1'b1; end
      OP_ORI:  begin dec.aluop = ALU_OR;  i_wr = 1'b1; end
      OP_LW:   begin dec.aluop = ALU_ADD; dec.mem2reg = 1'b1; dec_ext = 1'b1; i_wr = 1'b1; end
      OP_SW: begin
        dec.aluop     = ALU_ADD;
        dec.alusrc    = 1'b1;
        dec.mem_write = 1'b1;
        dec_ext       = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.aluop = ALU_ADD;
        dec.b_inv = 1'b1;
        dec_ext   = 1'b1;
        dec_beq   = (bus.opcode == OP_BEQ);
        dec_bne   = (bus.opcode == OP_BNE);
        use_rs    = 1'b1;
        use_rt    = 1'b1;
      end
      OP_J: dec_j = 1'b1;
      default: ;
    endcase
    if (i_wr) begin
      dec.we     = 1'b1;
      dec.dst    = bus.rt;
      dec.alusrc = 1'b1;
      use_rs     = 1'b1;
    end
  end

  // A taken branch already bubbles ID/EX, so it overrides any stall request.
  always_comb begin
    hit_ex  = id_ex.ctrl.we &&
              ((use_rs && bus.rs != '0 && bus.rs == id_ex.ctrl.dst) ||
               (use_rt && bus.rt != '0 && bus.rt == id_ex.ctrl.dst));
    hit_mem = ex_mem.we &&
              ((use_rs && bus.rs != '0 && bus.rs == ex_mem.dst) ||
               (use_rt && bus.rt != '0 && bus.rt == ex_mem.dst));
    if (FWD_EN) stall_raw = hit_ex && id_ex.ctrl.mem2reg;
    else        stall_raw = hit_ex || hit_mem;
    stall  = stall_raw && !bus.br_taken;
    bubble = stall_raw || bus.br_taken;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      if (ex_mem.we && ex_mem.dst != '0 && ex_mem.dst == id_ex.rs)      fwd_a = 2'b10;
      else if (mem_wb.we && mem_wb.dst != '0 && mem_wb.dst == id_ex.rs) fwd_a = 2'b01;
      if (ex_mem.we && ex_mem.dst != '0 && ex_mem.dst == id_ex.rt)      fwd_b = 2'b10;
      else if (mem_wb.we && mem_wb.dst != '0 && mem_wb.dst == id_ex.rt) fwd_b = 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!bus.hold) begin
      id_ex  <= bubble ? '0 : id_ex_t'{ctrl: dec, rs: bus.rs, rt: bus.rt};
      ex_mem <= ex_mem_t'{we: id_ex.ctrl.we, dst: id_ex.ctrl.dst,
                          mem_write: id_ex.ctrl.mem_write, mem2reg: id_ex.ctrl.mem2reg};
      mem_wb <= mem_wb_t'{we: ex_mem.we, dst: ex_mem.dst};
    end
  end

  assign bus.J           = dec_j;
  assign bus.BEQ         = dec_beq;
  assign bus.BNE         = dec_bne;
  assign bus.ExtOP       = dec_ext;
  assign bus.stall       = stall;
  assign bus.flush       = bus.br_taken || (dec_j && !stall);
  assign bus.ex_aluop    = id_ex.ctrl.aluop;
  assign bus.ex_b_invert = id_ex.ctrl.b_inv;
  assign bus.ex_alusrc   = id_ex.ctrl.alusrc;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.mem_write   = ex_mem.mem_write;
  assign bus.mem_mem2reg = ex_mem.mem2reg;
  assign bus.wb_write_en = mem_wb.we;
  assign bus.wb_dst      = mem_wb.dst;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RA_W, default 5, SHALL set the register-address width.
REQ-002 Parameter FWD_EN, default 1, SHALL select the hazard mode: 1 means forwarding plus load-use stall; 0 means no forwarding and a stall on any RAW hazard.
REQ-003 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 opcode, funct  in  6 each  SHALL be the ID-stage instruction fields.
REQ-006 rs, rt, rd  in  RA_W each  SHALL be the ID-stage register fields.
REQ-007 hold  in  1  SHALL be a memory-wait freeze of all pipeline control registers.
REQ-008 br_taken  in  1  SHALL indicate that the branch currently in EX resolved as taken.
REQ-009 J, BEQ, BNE, ExtOP  out  1 each  SHALL be combinational ID-stage decodes.
REQ-010 stall  out  1  SHALL hold the PC and IF/ID; flush  out  1  SHALL zero IF/ID.
REQ-011 ex_aluop  out  2, plus ex_b_invert and ex_alusrc  out  1 each, SHALL be the EX-stage controls.
REQ-012 fwd_a, fwd_b  out  2 each  SHALL be the EX operand-source selects.
REQ-013 mem_write and mem_mem2reg  out  1 each  SHALL be the MEM-stage controls.
REQ-014 wb_write_en  out  1 and wb_dst  out  RA_W  SHALL be the WB-stage controls.

Function
REQ-015 Decode table, with ALU codes AND=00, OR=01, ADD=10, SLT=11:
- R-type (op 00) funct 20/21: ADD; 22/23: ADD with b_invert; 24: AND; 25: OR; 2A: SLT with b_invert.
- In every R-type case: write enable 1, destination = rd, alusrc = 0.
- ADDI/ADDIU (08/09): ADD, ExtOP = 1.
- SLTI (0A): SLT with b_invert.
- ANDI (0C): AND. ORI (0D): OR.
- LW (23): ADD, mem2reg = 1, ExtOP = 1.
- SW (2B): ADD, memwrite = 1, ExtOP = 1, no register write.
- BEQ/BNE (04/05): ADD with b_invert, alusrc = 0, ExtOP = 1, no register write.
- J (02): J = 1, no register write.
- All I-type writes: destination = rt, alusrc = 1.
REQ-016 Any undefined opcode or funct SHALL decode as a NOP: all enables 0 and aluop 00.
REQ-017 The ID decode SHALL be captured into ID/EX, then flow through EX/MEM and MEM/WB, one stage per cycle.
REQ-018 Stage destination and write enable SHALL be carried with the instruction; ID/EX SHALL also keep rs and rt.
REQ-019 Per-edge priority SHALL be: reset > hold (all stages keep their value) > bubble into ID/EX > normal advance.
REQ-020 While stall or br_taken is active, ID/EX SHALL load a bubble with all enables 0; EX/MEM and MEM/WB SHALL still advance.
REQ-021 An ID source is "used" as follows: rs for every type except J; rt only for R-type, SW, BEQ and BNE.
REQ-022 Register 0 SHALL never cause a hazard or a forward.
REQ-023 FWD_EN = 1: stall = EX-stage instruction is LW, and its destination equals a used, nonzero ID source.
REQ-024 FWD_EN = 0: stall = a used, nonzero ID source matches the EX or MEM destination whose write enable is 1.
REQ-025 The register file writes in the first half of the cycle, so a WB-stage match SHALL NOT stall.
REQ-026 fwd_a (for ex_rs) SHALL be:
- 10 when the MEM stage writes ex_rs (nonzero);
- otherwise 01 when the WB stage writes it;
- otherwise 00.
REQ-027 fwd_b SHALL follow the same rules for ex_rt; with FWD_EN = 0 both selects SHALL be constant 00.
REQ-028 flush SHALL equal br_taken OR (J AND NOT stall).
REQ-029 br_taken together with stall SHALL resolve as a flush: bubble into ID/EX, and stall SHALL be forced to 0.
REQ-030 stall and flush SHALL be combinational, with no added latency; while hold = 1 both SHALL remain valid.

Reset
REQ-031 RST_N = 0 SHALL immediately clear every stage register to a bubble: all enables 0, aluop 00, destination and source fields 0.
REQ-032 As a consequence of REQ-031, stall, flush, fwd_a and fwd_b SHALL be 0 while in reset, except for the combinational J/flush decode of the live opcode.
REQ-033 Deassertion SHALL take effect on the next rising edge, with no residual hazard state.

Verification
REQ-034 Scenario: `LW r8` followed by `ADD r9,r8,r10`, FWD_EN = 1 -> stall = 1 for exactly one cycle, one bubble in EX, then fwd_a = 01 when the ADD reaches EX.
REQ-035 Scenario: `ADD r3,r1,r2` followed by `SUB r4,r3,r3` -> no stall; fwd_a = fwd_b = 10 when the SUB is in EX.
REQ-036 Scenario: the sequence of REQ-035 with FWD_EN = 0 -> stall = 1 for two cycles, fwd_a = fwd_b = 00, and the SUB reaches EX three cycles after the ADD.
REQ-037 Scenario: BEQ in EX with br_taken = 1 while ID holds an LW-dependent instruction -> flush = 1, stall = 0, and ID/EX becomes a bubble.
REQ-038 Scenario: hold = 1 for 3 cycles in mid-stream -> all stage outputs are unchanged; the pipeline resumes with no loss or duplication of instructions.
REQ-039 Scenario: RST_N pulsed low between clock edges with `LW r8` in MEM -> mem_mem2reg, wb_write_en and wb_dst clear immediately, with no clock edge required.
